// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage: opcodes, widths, FSM states
// and the operation classification used to pick the byte/word pass sequence.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 2 * DATA_W;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_ADDC = 4'b0100;
    localparam logic [3:0] OP_SUBC = 4'b0101;
    localparam logic [3:0] OP_CMP  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsByte,
        ClsWordArith,
        ClsWordLogic,
        ClsIllegal
    } op_cls_e;

    // cmp/mul are byte-only, so their word flag is ignored rather than rejected.
    function automatic op_cls_e op_class(input logic [3:0] op, input logic word);
        op_cls_e cls;
        case (op)
            OP_AND, OP_OR:    cls = word ? ClsWordLogic : ClsByte;
            OP_ADD, OP_SUB:   cls = word ? ClsWordArith : ClsByte;
            OP_ADDC, OP_SUBC: cls = word ? ClsIllegal : ClsByte;
            OP_CMP, OP_MUL:   cls = ClsByte;
            default:          cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    function automatic logic op_sets_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_exec_seq_if.sv
// Request, ALU and response signals of the ALU sequencing stage.
interface alu_exec_seq_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic              in_word;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;

    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_cout;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_result;
    logic              out_c;
    logic              out_z;

    modport slave (
        input  in_valid, in_op, in_word, in_a, in_b,
        input  alu_result, alu_zero, alu_cout,
        input  out_ready,
        output in_ready,
        output alu_op, alu_a, alu_b, alu_cin,
        output out_valid, out_result, out_c, out_z
    );

    modport master (
        output in_valid, in_op, in_word, in_a, in_b,
        output alu_result, alu_zero, alu_cout,
        output out_ready,
        input  in_ready,
        input  alu_op, alu_a, alu_b, alu_cin,
        input  out_valid, out_result, out_c, out_z
    );

endinterface

// File: rtl/alu_exec_seq.sv
// Sequences byte and word operations onto an 8-bit combinational ALU, one byte
// pass per cycle, and registers the result with C/Z flags for downstream.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter logic RESET_C = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_exec_seq_if.slave   bus_io
);

    state_e            state_q, state_d;
    op_cls_e           cls_q, cls_d;
    logic [3:0]        op_q, op_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              cy_lo_q, cy_lo_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    state_d = StLo;
                end
            end
            StLo: begin
                if (cls_q == ClsWordArith || cls_q == ClsWordLogic) begin
                    state_d = StHi;
                end else begin
                    state_d = StDone;
                end
            end
            StHi: begin
                state_d = StDone;
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: the ALU ports carry data only during a byte pass
    always_comb begin
        bus_io.in_ready  = (state_q == StIdle);
        bus_io.out_valid = (state_q == StDone);
        bus_io.alu_op    = 4'b0000;
        bus_io.alu_a     = '0;
        bus_io.alu_b     = '0;
        bus_io.alu_cin   = 1'b0;
        unique case (state_q)
            StLo: begin
                if (cls_q != ClsIllegal) begin
                    bus_io.alu_op  = op_q;
                    bus_io.alu_a   = a_q[DATA_W-1:0];
                    bus_io.alu_b   = b_q[DATA_W-1:0];
                    bus_io.alu_cin = c_q;
                end
            end
            StHi: begin
                bus_io.alu_a = a_q[WORD_W-1:DATA_W];
                bus_io.alu_b = b_q[WORD_W-1:DATA_W];
                if (cls_q == ClsWordArith) begin
                    bus_io.alu_op  = (op_q == OP_ADD) ? OP_ADDC : OP_SUBC;
                    bus_io.alu_cin = cy_lo_q;
                end else begin
                    bus_io.alu_op  = op_q;
                    bus_io.alu_cin = c_q;
                end
            end
            default: ;
        endcase
    end

    assign bus_io.out_result = result_q;
    assign bus_io.out_c      = c_q;
    assign bus_io.out_z      = z_q;

    // Datapath next-state: operands latched on accept, result/flags on pass edges
    always_comb begin
        op_d     = op_q;
        cls_d    = cls_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        cy_lo_d  = cy_lo_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    op_d  = bus_io.in_op;
                    cls_d = op_class(bus_io.in_op, bus_io.in_word);
                    a_d   = bus_io.in_a;
                    b_d   = bus_io.in_b;
                end
            end
            StLo: begin
                case (cls_q)
                    ClsIllegal: begin
                        result_d = '0;
                        z_d      = 1'b1;
                    end
                    ClsByte: begin
                        result_d = {{DATA_W{1'b0}}, bus_io.alu_result};
                        z_d      = bus_io.alu_zero;
                        if (op_sets_carry(op_q)) begin
                            c_d = bus_io.alu_cout;
                        end
                    end
                    default: begin
                        result_d = {{DATA_W{1'b0}}, bus_io.alu_result};
                        z_d      = bus_io.alu_zero;
                        cy_lo_d  = bus_io.alu_cout;
                    end
                endcase
            end
            StHi: begin
                result_d[WORD_W-1:DATA_W] = bus_io.alu_result;
                z_d = z_q & bus_io.alu_zero;
                // The high pass reports no usable carry, so word add/sub clear C.
                if (cls_q == ClsWordArith) begin
                    c_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 4'b0000;
            cls_q    <= ClsByte;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_q      <= RESET_C;
            z_q      <= 1'b0;
            cy_lo_q  <= 1'b0;
        end else begin
            op_q     <= op_d;
            cls_q    <= cls_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            cy_lo_q  <= cy_lo_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: behavioural 8-bit ALU attached to the ALU ports, a
// directed vector table, hand sequences for backpressure/reset, random ops.
module tb_alu_exec_seq;

    localparam logic RESET_C = 1'b0;
    localparam int   MaxLat  = 8;

    logic clk;
    logic rst_n;
    alu_exec_seq_if bus ();

    alu_exec_seq #(.RESET_C(RESET_C)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Combinational 8-bit ALU: {cout, zero, result}; sub carry is 1 = no borrow
    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        co;
        s = '0; p = '0; r = '0; co = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin s = {1'b0, a} + {1'b0, b};                 r = s[7:0]; co = s[8]; end
            4'h3: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1;         r = s[7:0]; co = s[8]; end
            4'h4: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin};   r = s[7:0]; co = s[8]; end
            4'h5: begin s = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};  r = s[7:0]; co = s[8]; end
            4'h6: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1;         r = s[7:0]; co = s[8]; end
            4'h8: begin p = {8'd0, a} * {8'd0, b};                 r = p[7:0]; co = |p[15:8]; end
            default: ;
        endcase
        return {co, (r == 8'd0), r};
    endfunction

    always_comb begin
        {bus.alu_cout, bus.alu_zero, bus.alu_result} =
            alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: word arithmetic done on 16-bit values, byte ops through the ALU
    task automatic ref_model(input logic [3:0] op, input logic w, input logic [15:0] a,
                             input logic [15:0] b, inout logic c, output logic [15:0] res,
                             output logic z, output int lat);
        logic [9:0] r;
        if (op == 4'h6 || op == 4'h8 || (!w && op <= 4'h5)) begin
            r   = alu_f(op, a[7:0], b[7:0], c);
            res = {8'h00, r[7:0]};
            if (op == 4'h2 || op == 4'h3 || op == 4'h8) c = r[9];
            lat = 2;
        end else if (op == 4'h0 || op == 4'h1) begin
            res = (op == 4'h0) ? (a & b) : (a | b);
            lat = 3;
        end else if (op == 4'h2 || op == 4'h3) begin
            res = (op == 4'h2) ? (a + b) : (a - b);
            c   = 1'b0;
            lat = 3;
        end else begin
            res = 16'h0000;
            lat = 2;
        end
        z = (res == 16'h0000);
    endtask

    typedef struct {
        int          lat;
        logic [3:0]  lo_op;
        logic        lo_cin;
        logic [3:0]  hi_op;
        logic        hi_cin;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        ready_seen;
        logic        busy_ok;
        logic        stable_ok;
        logic        idle_ok;
    } obs_t;

    task automatic run_op(input logic [3:0] op, input logic w, input logic [15:0] a,
                          input logic [15:0] b, input int hold, output obs_t o);
        o = '{default: '0};
        o.busy_ok = 1'b1;
        o.stable_ok = 1'b1;
        @(negedge clk);
        o.ready_seen = bus.in_ready;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_word = w; bus.in_a = a; bus.in_b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= MaxLat; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.out_valid) begin
                o.lat = k;
                break;
            end
            if (bus.in_ready) o.busy_ok = 1'b0;
            if (k == 1) begin o.lo_op = bus.alu_op; o.lo_cin = bus.alu_cin; end
            if (k == 2) begin o.hi_op = bus.alu_op; o.hi_cin = bus.alu_cin; end
        end
        o.res = bus.out_result; o.c = bus.out_c; o.z = bus.out_z;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.out_result !== o.res ||
                bus.out_c !== o.c || bus.out_z !== o.z) o.stable_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        o.idle_ok = bus.in_ready && !bus.out_valid;
    endtask

    task automatic check_op(input string tag, input obs_t o, input logic [15:0] res,
                            input logic c, input logic z, input int lat);
        chk({tag, ".ready"},  {31'd0, o.ready_seen}, 32'd1);
        chk({tag, ".lat"},    o.lat, lat);
        chk({tag, ".result"}, {16'd0, o.res}, {16'd0, res});
        chk({tag, ".c"},      {31'd0, o.c}, {31'd0, c});
        chk({tag, ".z"},      {31'd0, o.z}, {31'd0, z});
        chk({tag, ".busy"},   {31'd0, o.busy_ok}, 32'd1);
        chk({tag, ".idle"},   {31'd0, o.idle_ok}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        int          lat;
        logic [3:0]  lo_op;
        logic [3:0]  hi_op;
        logic        cin;
        logic        chk_lo_cin;
        logic        chk_hi_cin;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic w, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] res, input logic c,
                                input logic z, input int lat, input logic [3:0] lo_op,
                                input logic [3:0] hi_op, input logic cin,
                                input logic chk_lo_cin, input logic chk_hi_cin);
        vec_t v;
        v = '{op, w, a, b, res, c, z, lat, lo_op, hi_op, cin, chk_lo_cin, chk_hi_cin};
        return v;
    endfunction

    vec_t       vecs[16];
    obs_t       o;
    logic       mc;
    logic [15:0] er;
    logic       ez;
    int         el;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 4'h0; bus.in_word = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst.in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.result",    {16'd0, bus.out_result}, 32'd0);
        chk("rst.c",         {31'd0, bus.out_c}, {31'd0, RESET_C});
        chk("rst.z",         {31'd0, bus.out_z}, 32'd0);
        chk("rst.alu",       {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //          op    w     a        b        res      c     z    lat lo    hi    cin   lc    hc
        vecs[0]  = mk(4'h2, 1'b0, 16'h00F0, 16'h0020, 16'h0010, 1'b1, 1'b0, 2, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(4'h2, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 3, 4'h2, 4'h4, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(4'h3, 1'b1, 16'h1000, 16'h1000, 16'h0000, 1'b0, 1'b1, 3, 4'h3, 4'h5, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(4'h2, 1'b0, 16'h0080, 16'h0080, 16'h0000, 1'b1, 1'b1, 2, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(4'hA, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b1, 2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(4'h0, 1'b1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1, 1'b0, 3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(4'h1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(4'h4, 1'b1, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b1, 2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(4'h6, 1'b1, 16'h1155, 16'h2255, 16'h0000, 1'b1, 1'b1, 2, 4'h6, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(4'h8, 1'b1, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 2, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(4'h3, 1'b0, 16'h0005, 16'h0006, 16'h00FF, 1'b0, 1'b0, 2, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(4'h3, 1'b0, 16'h0007, 16'h0003, 16'h0004, 1'b1, 1'b0, 2, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(4'h4, 1'b0, 16'h0010, 16'h0020, 16'h0031, 1'b1, 1'b0, 2, 4'h4, 4'h0, 1'b1, 1'b1, 1'b0);
        vecs[13] = mk(4'h5, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 2, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0);
        vecs[14] = mk(4'h1, 1'b0, 16'h00A0, 16'h000B, 16'h00AB, 1'b1, 1'b0, 2, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(4'h3, 1'b1, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 3, 4'h3, 4'h5, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 0, o);
            check_op(tag, o, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].lat);
            chk({tag, ".lo_op"}, {28'd0, o.lo_op}, {28'd0, vecs[i].lo_op});
            if (vecs[i].lat == 3) chk({tag, ".hi_op"}, {28'd0, o.hi_op}, {28'd0, vecs[i].hi_op});
            if (vecs[i].chk_lo_cin) chk({tag, ".lo_cin"}, {31'd0, o.lo_cin}, {31'd0, vecs[i].cin});
            if (vecs[i].chk_hi_cin) chk({tag, ".hi_cin"}, {31'd0, o.hi_cin}, {31'd0, vecs[i].cin});
        end
        mc = vecs[15].c;

        // Backpressure: five cycles with out_ready low
        ref_model(4'h2, 1'b0, 16'h00FF, 16'h0001, mc, er, ez, el);
        run_op(4'h2, 1'b0, 16'h00FF, 16'h0001, 5, o);
        check_op("bp", o, er, mc, ez, el);
        chk("bp.stable", {31'd0, o.stable_ok}, 32'd1);

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  rop;
            logic        rw;
            logic [15:0] ra, rb;
            int          hold;
            rop  = 4'($urandom_range(0, 15));
            rw   = 1'($urandom);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            hold = $urandom_range(0, 2);
            if (n % 4 == 0) rb = ra;
            ref_model(rop, rw, ra, rb, mc, er, ez, el);
            run_op(rop, rw, ra, rb, hold, o);
            check_op($sformatf("rnd%0d_op%0h_w%0d", n, rop, rw), o, er, mc, ez, el);
            if (hold > 0) chk($sformatf("rnd%0d.stable", n), {31'd0, o.stable_ok}, 32'd1);
        end

        // Reset during the high pass of a word add, with C set beforehand
        ref_model(4'h2, 1'b0, 16'h00FF, 16'h0001, mc, er, ez, el);
        run_op(4'h2, 1'b0, 16'h00FF, 16'h0001, 0, o);
        check_op("pre_rst", o, er, mc, ez, el);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 4'h2; bus.in_word = 1'b1;
        bus.in_a = 16'h12FF; bus.in_b = 16'h0001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid.hi_op", {28'd0, bus.alu_op}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid.result",    {16'd0, bus.out_result}, 32'd0);
        chk("mid.c",         {31'd0, bus.out_c}, {31'd0, RESET_C});
        chk("mid.z",         {31'd0, bus.out_z}, 32'd0);
        chk("mid.alu",       {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mc = RESET_C;
        begin
            logic saw_valid;
            saw_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (bus.out_valid || !bus.in_ready) saw_valid = 1'b1;
            end
            chk("post_rst.quiet", {31'd0, saw_valid}, 32'd0);
        end
        ref_model(4'h3, 1'b1, 16'hABCD, 16'h1234, mc, er, ez, el);
        run_op(4'h3, 1'b1, 16'hABCD, 16'h1234, 1, o);
        check_op("post_rst", o, er, mc, ez, el);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
